// File: rtl/cp0_unit_pkg.sv
// Shared definitions for the coprocessor-0 block: operation encodings,
// register indices, STATUS/CAUSE bit positions and FSM state encoding.
package cp0_unit_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned IDX_W = 5;

    // Coprocessor operation issued by the decode controller
    typedef enum logic [1:0] {
        CP_NONE  = 2'b00,
        CP_STORE = 2'b01,
        CP_ERET  = 2'b10,
        CP_RSVD  = 2'b11
    } cp_oper_e;

    // Default CP0 register indices
    localparam logic [IDX_W-1:0] CP0_IDX_STATUS = 5'd12;
    localparam logic [IDX_W-1:0] CP0_IDX_CAUSE  = 5'd13;
    localparam logic [IDX_W-1:0] CP0_IDX_EPC    = 5'd14;
    localparam logic [IDX_W-1:0] CP0_IDX_EHBR   = 5'd25;

    // Register bit positions
    localparam int unsigned STATUS_IE_BIT    = 0;
    localparam int unsigned CAUSE_PEND_BIT   = 0;
    localparam int unsigned CAUSE_INHDLR_BIT = 1;

    // Interrupt service FSM
    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_HANDLER = 1'b1
    } cp0_state_e;

endpackage

// File: rtl/cp0_unit_if.sv
// Decode-controller <-> CP0 bundle.
//   master: controller side (drives operation, indices, data, interrupt inputs)
//   slave : CP0 side (returns read data, redirect request, handler flag)
interface cp0_unit_if;
    import cp0_unit_pkg::*;

    logic             en;
    cp_oper_e         cp_oper;
    logic [IDX_W-1:0] addr_r;
    logic [XLEN-1:0]  data_r;
    logic [IDX_W-1:0] addr_w;
    logic [XLEN-1:0]  data_w;
    logic [XLEN-1:0]  ret_addr;
    logic             ir_en;
    logic             ir_in;
    logic             jump_en;
    logic [XLEN-1:0]  jump_addr;
    logic             in_handler;

    modport master (
        output en, cp_oper, addr_r, addr_w, data_w, ret_addr, ir_en, ir_in,
        input  data_r, jump_en, jump_addr, in_handler
    );

    modport slave (
        input  en, cp_oper, addr_r, addr_w, data_w, ret_addr, ir_en, ir_in,
        output data_r, jump_en, jump_addr, in_handler
    );

endinterface

// File: rtl/cp0_unit_irq_edge_latch.sv
// Rising-edge detector and pending latch for the external interrupt.
//   clk, rst   : clock, async active-low reset
//   ir_in      : level interrupt request, synchronous to clk
//   clr        : interrupt taken this cycle (clears pending)
//   pending    : registered pending flag
module cp0_unit_irq_edge_latch (
    input  logic clk,
    input  logic rst,
    input  logic ir_in,
    input  logic clr,
    output logic pending
);

    logic ir_prev_q;
    logic pending_q, pending_d;
    logic rise_c;

    // A new edge arriving while the old one is taken keeps pending set
    always_comb begin
        rise_c    = ir_in & ~ir_prev_q;
        pending_d = rise_c | (pending_q & ~clr);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ir_prev_q <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            ir_prev_q <= ir_in;
            pending_q <= pending_d;
        end
    end

    assign pending = pending_q;

endmodule

// File: rtl/cp0_unit.sv
// Coprocessor-0 register file and interrupt responder.
//   clk, rst : clock, async active-low reset
//   bus      : slave side of cp0_unit_if
//              in : en, cp_oper, addr_r, addr_w, data_w, ret_addr, ir_en, ir_in
//              out: data_r (comb), jump_en (comb), jump_addr (comb), in_handler
module cp0_unit
    import cp0_unit_pkg::*;
#(
    parameter logic [XLEN-1:0]  HANDLER_RESET = 32'h0000_0008,
    parameter logic [IDX_W-1:0] REG_STATUS    = CP0_IDX_STATUS,
    parameter logic [IDX_W-1:0] REG_CAUSE     = CP0_IDX_CAUSE,
    parameter logic [IDX_W-1:0] REG_EPC       = CP0_IDX_EPC,
    parameter logic [IDX_W-1:0] REG_EHBR      = CP0_IDX_EHBR
) (
    input  logic      clk,
    input  logic      rst,
    cp0_unit_if.slave bus
);

    cp0_state_e      state_q, state_d;
    logic            ie_q, ie_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic [XLEN-1:0] ehbr_q, ehbr_d;

    logic            pending;
    logic            take_c;
    logic            eret_c;
    logic            store_c;
    logic [XLEN-1:0] cause_c;
    logic [XLEN-1:0] rdata_c;

    // Pending interrupt tracking; cleared only by an actual take
    cp0_unit_irq_edge_latch u_irq (
        .clk     (clk),
        .rst     (rst),
        .ir_in   (bus.ir_in),
        .clr     (take_c),
        .pending (pending)
    );

    // Take only in an empty decode slot so no CP0 op is lost by the flush
    always_comb begin
        store_c = bus.en & (bus.cp_oper == CP_STORE);
        eret_c  = bus.en & (bus.cp_oper == CP_ERET);
        take_c  = (state_q == ST_IDLE) & pending & ie_q & bus.ir_en &
                  bus.en & (bus.cp_oper == CP_NONE);
    end

    // Next-state and register update
    always_comb begin
        state_d = state_q;
        ie_d    = ie_q;
        epc_d   = epc_q;
        ehbr_d  = ehbr_q;

        if (store_c) begin
            case (bus.addr_w)
                REG_STATUS: ie_d   = bus.data_w[STATUS_IE_BIT];
                REG_EPC:    epc_d  = bus.data_w;
                REG_EHBR:   ehbr_d = bus.data_w;
                default:    ;
            endcase
        end

        if (take_c) begin
            epc_d   = bus.ret_addr;
            state_d = ST_HANDLER;
        end

        if (eret_c) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            ie_q    <= 1'b0;
            epc_q   <= '0;
            ehbr_q  <= HANDLER_RESET;
        end else begin
            state_q <= state_d;
            ie_q    <= ie_d;
            epc_q   <= epc_d;
            ehbr_q  <= ehbr_d;
        end
    end

    // MFC0 read mux
    always_comb begin
        cause_c                   = '0;
        cause_c[CAUSE_PEND_BIT]   = pending;
        cause_c[CAUSE_INHDLR_BIT] = (state_q == ST_HANDLER);

        rdata_c = '0;
        case (bus.addr_r)
            REG_STATUS: rdata_c[STATUS_IE_BIT] = ie_q;
            REG_CAUSE:  rdata_c = cause_c;
            REG_EPC:    rdata_c = epc_q;
            REG_EHBR:   rdata_c = ehbr_q;
            default:    rdata_c = '0;
        endcase
    end

    // take and ERET are mutually exclusive (take requires cp_oper == NONE)
    assign bus.data_r     = rdata_c;
    assign bus.jump_en    = take_c | eret_c;
    assign bus.jump_addr  = eret_c ? epc_q : (take_c ? ehbr_q : '0);
    assign bus.in_handler = (state_q == ST_HANDLER);

endmodule

// File: doc/cp0_unit.md
# cp0_unit

Coprocessor-0 and interrupt responder for the 5-stage MIPS pipeline. Executes the coprocessor operations the decode controller issues (MTC0 store, MFC0 read, ERET) and owns STATUS/CAUSE/EPC/handler-base registers. Latches an external interrupt and, at a safe decode slot, raises `jump_en`/`jump_addr` so the controller flushes ID and the PC redirects to the handler. Also redirects to EPC on ERET.

## Interface
Parameters:
- `HANDLER_RESET`, 32'h0000_0008, reset value of the handler-base register.
- `REG_STATUS`, 12, CP0 index of STATUS.
- `REG_CAUSE`, 13, CP0 index of CAUSE.
- `REG_EPC`, 14, CP0 index of EPC.
- `REG_EHBR`, 25, CP0 index of handler base.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: reset, asynchronous, active-low.
- `en` in 1: ID stage enable; operations commit only when 1.
- `cp_oper` in 2: 00 none, 01 store (MTC0), 10 ERET, 11 reserved (no-op).
- `addr_r` in 5: CP0 read index (MFC0 rd field).
- `data_r` out 32: combinational read data.
- `addr_w` in 5: CP0 write index.
- `data_w` in 32: MTC0 write data (forwarded rt).
- `ret_addr` in 32: PC saved to EPC when an interrupt is taken.
- `ir_en` in 1: global interrupt gate from controller.
- `ir_in` in 1: external interrupt request, synchronous to `clk`, level.
- `jump_en` out 1: redirect request to controller/PC mux.
- `jump_addr` out 32: redirect target.
- `in_handler` out 1: 1 while servicing an interrupt.

## Operation
- Registers: STATUS (bit0 IE, other bits read 0), CAUSE (read-only; bit0 pending, bit1 in_handler), EPC (RW), EHBR (RW). Unlisted indices read 0; writes to them and to CAUSE are ignored.
- Edge detect: `ir_prev` register; rising edge of `ir_in` sets `pending`. Pending stays set until taken; set and clear in the same cycle → set wins.
- FSM states IDLE, HANDLER.
- IDLE: take = `pending & IE & ir_en & en & cp_oper==00`. On take: `jump_en`=1, `jump_addr`=EHBR (same cycle); at edge EPC←`ret_addr`, pending←0 (unless new edge), state→HANDLER.
- HANDLER: interrupts never taken (no nesting); new edges still latch `pending`.
- ERET (`cp_oper`=10, `en`=1) in either state: `jump_en`=1, `jump_addr`=EPC; at edge state→IDLE.
- MTC0 (`cp_oper`=01, `en`=1): target register←`data_w` at edge. MTC0 EPC concurrent with nothing else; take is suppressed that cycle, so interrupt is deferred ≥1 cycle.
- `en`=0: no register, state or pending-clear update except edge capture; `jump_en`=0.
- Reset values: STATUS=0, EPC=0, EHBR=`HANDLER_RESET`, pending=0, ir_prev=0, state=IDLE; outputs `jump_en`=0, `jump_addr`=0, `in_handler`=0, `data_r`=0 for any index except EHBR.

## Timing
- `data_r`, `jump_en`, `jump_addr` combinational from registers/inputs; zero latency.
- Writes visible on `data_r` the cycle after the commit edge; same-cycle read returns old value.
- Interrupt latency: edge at cycle N sets pending at edge N; earliest take in cycle N+1.
- `jump_en` held 1 only while take/ERET condition holds; it is a one-cycle pulse when `en` stays 1 since state/pending change at the next edge.
- Reset asserted mid-handler: state→IDLE, pending lost, immediately and asynchronously.

## Structure
- Shared package: `cp_oper` encodings (CP_NONE, CP_STORE, CP_ERET), CP0 register indices, STATUS/CAUSE bit positions, FSM state encoding.
- One sub-module natural: `irq_edge_latch` (ir_prev, rising-edge detect, pending set/clear with set priority).

## Test plan
- Reset: `rst`=0 → `data_r`=0 at index 12, 32'h8 at index 25, `jump_en`=0, `in_handler`=0.
- MTC0 STATUS←1, then `ir_in` 0→1, `ret_addr`=32'h40, `ir_en`=1 → next cycle `jump_en`=1, `jump_addr`=32'h8; after edge EPC reads 32'h40, `in_handler`=1, CAUSE=2'b10.
- In HANDLER, second `ir_in` edge → no `jump_en`; ERET → `jump_en`=1, `jump_addr`=32'h40; then pending interrupt taken in following cycle.
- IE=0 with `ir_in` edge → no take, CAUSE bit0=1; MTC0 STATUS←1 cycle suppresses take, take occurs the cycle after.
- `en`=0 during ERET or pending take → `jump_en`=0, state unchanged; `en`=1 next cycle → redirect occurs.
- Async `rst` pulse while in HANDLER with pending set → `in_handler`=0, CAUSE=0 without waiting for `clk`.
